pio_xfer_ctrl: RTL and testbench

- Host-side PIO sequencer that sits directly upstream of the PIO timing controller.
- Accepts single-word host register requests and drives the ATA address lines (DA, nCS0/nCS1) and write data.
- Issues the one-cycle go/we strobe to the timing controller and captures read data on its dstrb.
- Acknowledges the host when the timing controller reports done; done guarantees address and data hold time.

---
 rtl/ata_pio_pkg.sv | 20 ++
 rtl/pio_adr_reg.sv | 52 +++++
 rtl/pio_xfer_ctrl.sv | 131 +++++++++++++
 tb/tb_pio_xfer_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ata_pio_pkg.sv
// Shared definitions for the host-side ATA PIO sequencer: FSM state
// encoding, the address bit that selects the chip select, and default widths.
package ata_pio_pkg;

  // Default ATA data bus width and host register address width
  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 4;

  // Address bit choosing between command block (CS0) and control block (CS1)
  localparam int CS_SEL_BIT = 3;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_ACK   = 2'b11
  } pio_state_t;

endpackage : ata_pio_pkg

// File: rtl/pio_adr_reg.sv
// Holding register for the ATA address lines, chip selects, direction and
// write data. 'load' captures a new request; 'clr_cs' negates both chip
// selects while keeping address and data stable for hold time.
module pio_adr_reg
  import ata_pio_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              rst,
  input  logic              load,
  input  logic              clr_cs,
  input  logic [AWIDTH-1:0] adr,
  input  logic              we_in,
  input  logic [DWIDTH-1:0] dat_in,
  output logic [2:0]        DA,
  output logic              nCS0,
  output logic              nCS1,
  output logic              we,
  output logic [DWIDTH-1:0] DD_o
);

  // Capture request fields on load; drop chip selects at end of transfer
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      DA   <= 3'b000;
      nCS0 <= 1'b1;
      nCS1 <= 1'b1;
      we   <= 1'b0;
      DD_o <= {DWIDTH{1'b0}};
    end else if (rst) begin
      DA   <= 3'b000;
      nCS0 <= 1'b1;
      nCS1 <= 1'b1;
      we   <= 1'b0;
      DD_o <= {DWIDTH{1'b0}};
    end else if (load) begin
      DA   <= adr[2:0];
      // Exactly one chip select goes low: adr[3]=0 -> CS0, adr[3]=1 -> CS1
      nCS0 <= adr[CS_SEL_BIT];
      nCS1 <= ~adr[CS_SEL_BIT];
      we   <= we_in;
      DD_o <= dat_in;
    end else if (clr_cs) begin
      nCS0 <= 1'b1;
      nCS1 <= 1'b1;
    end
  end

endmodule : pio_adr_reg

// File: rtl/pio_xfer_ctrl.sv
// Host-side PIO sequencer in front of the PIO timing controller.
// Accepts one host register request at a time, presents address/chip
// select/write data, pulses go for one cycle, captures read data on the
// timing controller's data strobe and acknowledges on its done.
// Optional build macro PIO_WRITE_POST_EN: writes are acknowledged while
// the transfer is being issued and complete in the background.
module pio_xfer_ctrl
  import ata_pio_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_adr,
  input  logic [DWIDTH-1:0] host_dat_i,
  output logic [DWIDTH-1:0] host_dat_o,
  output logic              ack,
  output logic              go,
  output logic              we,
  input  logic              tc_oe,
  input  logic              tc_done,
  input  logic              tc_dstrb,
  output logic [2:0]        DA,
  output logic              nCS0,
  output logic              nCS1,
  output logic [DWIDTH-1:0] DD_o,
  input  logic [DWIDTH-1:0] DD_i,
  output logic              DD_oe
);

  pio_state_t state_r;
  logic       posted_r;
  logic       load_s;
  logic       clr_cs_s;

  // Decode register-file controls from the current state
  always_comb begin
    load_s   = 1'b0;
    clr_cs_s = 1'b0;
    case (state_r)
      ST_IDLE:  load_s   = req;
      ST_WAIT:  clr_cs_s = tc_done;
      default: begin
        load_s   = 1'b0;
        clr_cs_s = 1'b0;
      end
    endcase
  end

  pio_adr_reg #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_adr_reg (
    .clk    (clk),
    .nReset (nReset),
    .rst    (rst),
    .load   (load_s),
    .clr_cs (clr_cs_s),
    .adr    (req_adr),
    .we_in  (req_we),
    .dat_in (host_dat_i),
    .DA     (DA),
    .nCS0   (nCS0),
    .nCS1   (nCS1),
    .we     (we),
    .DD_o   (DD_o)
  );

  // Data bus is driven only while the timing controller enables it on a write
  assign DD_oe = tc_oe & we;

  // Transfer sequencer with registered go/ack strobes and read-data latch
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r    <= ST_IDLE;
      go         <= 1'b0;
      ack        <= 1'b0;
      posted_r   <= 1'b0;
      host_dat_o <= {DWIDTH{1'b0}};
    end else if (rst) begin
      state_r    <= ST_IDLE;
      go         <= 1'b0;
      ack        <= 1'b0;
      posted_r   <= 1'b0;
      host_dat_o <= {DWIDTH{1'b0}};
    end else begin
      go  <= 1'b0;
      ack <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            state_r <= ST_ISSUE;
            go      <= 1'b1;
`ifdef PIO_WRITE_POST_EN
            // Posted write: acknowledge during ISSUE, finish in background
            posted_r <= req_we;
            ack      <= req_we;
`else
            posted_r <= 1'b0;
`endif
          end
        end
        ST_ISSUE: begin
          // A done seen here is illegal and deliberately ignored
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tc_dstrb && !we) begin
            host_dat_o <= DD_i;
          end
          if (tc_done) begin
            state_r <= ST_ACK;
            ack     <= ~posted_r;
          end
        end
        ST_ACK: begin
          state_r  <= ST_IDLE;
          posted_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : pio_xfer_ctrl

// File: tb/tb_pio_xfer_ctrl.sv
// Self-checking bench for pio_xfer_ctrl. The bench plays both the host and
// the timing controller and predicts every output from the transfer rules.
// Build with +define+PIO_WRITE_POST_EN to exercise posted writes.
module tb_pio_xfer_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;
`ifdef PIO_WRITE_POST_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nReset, rst, req, req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] host_dat_i, host_dat_o, DD_o, DD_i;
  logic          ack, go, we, tc_oe, tc_done, tc_dstrb, nCS0, nCS1, DD_oe;
  logic [2:0]    DA;

  int            n_checks = 0;
  int            n_errors = 0;
  int            ack_seen = 0;
  int            ack_exp  = 0;
  logic [DW-1:0] last_rd  = 16'h0000;

  always #5 clk = ~clk;

  pio_xfer_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .nReset(nReset), .rst(rst), .req(req), .req_we(req_we),
    .req_adr(req_adr), .host_dat_i(host_dat_i), .host_dat_o(host_dat_o),
    .ack(ack), .go(go), .we(we), .tc_oe(tc_oe), .tc_done(tc_done),
    .tc_dstrb(tc_dstrb), .DA(DA), .nCS0(nCS0), .nCS1(nCS1), .DD_o(DD_o),
    .DD_i(DD_i), .DD_oe(DD_oe)
  );

  // Count acknowledge cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (ack === 1'b1) ack_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Address/select/direction/data the DUT must be presenting for a request
  task automatic check_hold(input string tag, input logic w, input logic [3:0] a, input logic [15:0] d);
    check_eq({tag, "_DA"}, {29'd0, DA}, {29'd0, a[2:0]});
    check_eq({tag, "_nCS0"}, {31'd0, nCS0}, {31'd0, a[3]});
    check_eq({tag, "_nCS1"}, {31'd0, nCS1}, {31'd0, ~a[3]});
    check_eq({tag, "_we"}, {31'd0, we}, {31'd0, w});
    check_eq({tag, "_DDo"}, {16'd0, DD_o}, {16'd0, d});
  endtask

  // One full host transfer with the bench acting as timing controller
  task automatic do_xfer(input logic w, input logic [3:0] a, input logic [15:0] wd,
                         input logic [15:0] rd, input int dly, input bit same, input bit hold);
    bit pst;
    bit early;
    pst   = POST && w;
    early = !same && (dly > 0);
    req = 1'b1; req_we = w; req_adr = a; host_dat_i = wd;
    step();
    check_eq("go_issue", {31'd0, go}, 32'd1);
    check_eq("ack_issue", {31'd0, ack}, {31'd0, pst});
    check_hold("issue", w, a, wd);
    if (pst && !hold) req = 1'b0;
    step();
    check_eq("go_wait", {31'd0, go}, 32'd0);
    for (int i = 0; i < dly; i++) begin
      tc_oe    = 1'($urandom);
      tc_dstrb = early && (i == dly - 1);
      DD_i     = tc_dstrb ? rd : 16'($urandom);
      if (tc_dstrb && !w) last_rd = rd;
      #1;
      check_eq("dd_oe", {31'd0, DD_oe}, {31'd0, tc_oe & w});
      step();
      check_eq("ack_wait", {31'd0, ack}, 32'd0);
      check_eq("go_wait2", {31'd0, go}, 32'd0);
      check_eq("rdat_wait", {16'd0, host_dat_o}, {16'd0, last_rd});
      check_hold("wait", w, a, wd);
    end
    tc_done  = 1'b1;
    tc_dstrb = w ? 1'($urandom) : !early;
    DD_i     = tc_dstrb ? rd : 16'($urandom);
    if (tc_dstrb && !w) last_rd = rd;
    step();
    ack_exp++;
    check_eq("ack_done", {31'd0, ack}, {31'd0, !pst});
    check_eq("nCS0_ack", {31'd0, nCS0}, 32'd1);
    check_eq("nCS1_ack", {31'd0, nCS1}, 32'd1);
    check_eq("rdat_ack", {16'd0, host_dat_o}, {16'd0, last_rd});
    check_eq("DA_ack", {29'd0, DA}, {29'd0, a[2:0]});
    tc_done = 1'b0; tc_dstrb = 1'b0; tc_oe = 1'b0;
    if (!hold) req = 1'b0;
    step();
    check_eq("ack_idle", {31'd0, ack}, 32'd0);
    check_eq("go_idle", {31'd0, go}, 32'd0);
  endtask

  initial begin
    nReset = 1'b1; rst = 1'b0; req = 1'b0; req_we = 1'b0; req_adr = 4'h0;
    host_dat_i = 16'h0000; DD_i = 16'h0000;
    tc_oe = 1'b0; tc_done = 1'b0; tc_dstrb = 1'b0;

    // Reset: async pulse, then synchronous reset with a request pending
    #2 nReset = 1'b0;
    #10;
    check_eq("rst_nCS0", {31'd0, nCS0}, 32'd1);
    check_eq("rst_nCS1", {31'd0, nCS1}, 32'd1);
    check_eq("rst_go", {31'd0, go}, 32'd0);
    nReset = 1'b1; rst = 1'b1; req = 1'b1; req_we = 1'b1; req_adr = 4'h7;
    host_dat_i = 16'hFFFF; tc_oe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("srst_nCS0", {31'd0, nCS0}, 32'd1);
      check_eq("srst_nCS1", {31'd0, nCS1}, 32'd1);
      check_eq("srst_go", {31'd0, go}, 32'd0);
      check_eq("srst_ack", {31'd0, ack}, 32'd0);
      check_eq("srst_DDoe", {31'd0, DD_oe}, 32'd0);
      check_eq("srst_DA", {29'd0, DA}, 32'd0);
      check_eq("srst_DDo", {16'd0, DD_o}, 32'd0);
      check_eq("srst_rdat", {16'd0, host_dat_o}, 32'd0);
    end
    rst = 1'b0; req = 1'b0; tc_oe = 1'b0;
    step();

    // CS0 write, CS1 read, held request
    do_xfer(1'b1, 4'h7, 16'hA55A, 16'h0000, 2, 1'b1, 1'b0);
    do_xfer(1'b0, 4'hE, 16'h0000, 16'h1234, 3, 1'b0, 1'b0);
    do_xfer(1'b0, 4'h1, 16'h0000, 16'hC0DE, 1, 1'b1, 1'b1);
    do_xfer(1'b1, 4'h9, 16'h7E57, 16'h0000, 0, 1'b1, 1'b0);

    // Abort a read during WAIT
    req = 1'b1; req_we = 1'b0; req_adr = 4'h3;
    step();
    step();
    rst = 1'b1; req = 1'b0; tc_dstrb = 1'b1; DD_i = 16'hDEAD;
    step();
    last_rd = 16'h0000;
    check_eq("abort_nCS0", {31'd0, nCS0}, 32'd1);
    check_eq("abort_nCS1", {31'd0, nCS1}, 32'd1);
    check_eq("abort_ack", {31'd0, ack}, 32'd0);
    check_eq("abort_rdat", {16'd0, host_dat_o}, 32'd0);
    rst = 1'b0; tc_dstrb = 1'b0; tc_done = 1'b1;
    step();
    check_eq("abort_ack2", {31'd0, ack}, 32'd0);
    check_eq("abort_go", {31'd0, go}, 32'd0);
    tc_done = 1'b0;
    step();
    do_xfer(1'b0, 4'hB, 16'h0000, 16'h4321, 2, 1'b0, 1'b0);

`ifdef PIO_WRITE_POST_EN
    // Posted write followed immediately by a read request
    req = 1'b1; req_we = 1'b1; req_adr = 4'h2; host_dat_i = 16'hBEEF;
    step();
    check_eq("post_ack", {31'd0, ack}, 32'd1);
    check_eq("post_go", {31'd0, go}, 32'd1);
    ack_exp++;
    req_we = 1'b0; req_adr = 4'h9; host_dat_i = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("post_stall_go", {31'd0, go}, 32'd0);
      check_eq("post_stall_ack", {31'd0, ack}, 32'd0);
      check_hold("post_wait", 1'b1, 4'h2, 16'hBEEF);
    end
    tc_done = 1'b1;
    step();
    check_eq("post_noack", {31'd0, ack}, 32'd0);
    check_eq("post_go_ack", {31'd0, go}, 32'd0);
    tc_done = 1'b0;
    step();
    check_eq("post_go_idle", {31'd0, go}, 32'd0);
    step();
    check_eq("post_rd_go", {31'd0, go}, 32'd1);
    check_hold("post_rd", 1'b0, 4'h9, 16'h0000);
    step();
    tc_done = 1'b1; tc_dstrb = 1'b1; DD_i = 16'h5AA5;
    step();
    last_rd = 16'h5AA5;
    ack_exp++;
    check_eq("post_rd_ack", {31'd0, ack}, 32'd1);
    check_eq("post_rd_dat", {16'd0, host_dat_o}, 32'h5AA5);
    tc_done = 1'b0; tc_dstrb = 1'b0; req = 1'b0;
    step();
`endif

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      do_xfer(1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    req = 1'b0;
    step();
    step();
    check_eq("ack_count", ack_seen, ack_exp);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pio_xfer_ctrl
